// File: rtl/cm_sort_gather.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cm_sort_gather                                               |
// | Brief   : Stream-to-frame collector feeding cm_sort. Packs DCNT words  |
// |           into one frame, pads short frames with all-ones words and    |
// |           emits a single-cycle valid pulse per frame.                  |
// | Option  : CM_SORT_GATHER_TMO_EN enables an idle timeout that flushes a |
// |           partial frame after TMO_CYC idle cycles.                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cm_sort_gather #(
  parameter int DCNT    = 4,
  parameter int DWIDTH  = 16,
  parameter int TMO_CYC = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_vld,
  output logic                        o_rdy,
  input  logic [DWIDTH-1:0]           i_data,
  input  logic                        i_last,
  output logic                        o_vld,
  output logic [DCNT*DWIDTH-1:0]      o_data,
  output logic [$clog2(DCNT+1)-1:0]   o_cnt
);

  localparam int IDX_W = $clog2(DCNT);
  localparam int CNT_W = $clog2(DCNT+1);
  localparam logic [DCNT*DWIDTH-1:0] c_ones = '1;

  logic                     r_rdy;
  logic                     r_vld;
  logic [DCNT*DWIDTH-1:0]   r_data;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [DCNT*DWIDTH-1:0]   r_buf;

  logic                     w_beat;
  logic                     w_close;
  logic                     w_tmo;
  logic [DCNT*DWIDTH-1:0]   w_frame;

  assign w_beat  = i_vld & r_rdy;
  assign w_close = w_beat & (i_last | (r_idx == IDX_W'(DCNT-1)));

  // Buffer contents with the incoming word merged into slot r_idx.
  for (genvar j = 0; j < DCNT; j++) begin : g_slot
    assign w_frame[j*DWIDTH +: DWIDTH] =
        (w_beat && (r_idx == IDX_W'(j))) ? i_data : r_buf[j*DWIDTH +: DWIDTH];
  end

`ifdef CM_SORT_GATHER_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC+1);
  logic [TMO_W-1:0] r_tmo;

  // A partial frame times out on the edge where the idle count would reach
  // TMO_CYC; an arriving beat on that same edge wins and restarts the count.
  assign w_tmo = (r_idx != '0) && !w_beat && (r_tmo == TMO_W'(TMO_CYC-1));

  // Idle counter: runs only while a partial frame is held, cleared by beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo <= '0;
    end else if (w_beat || (r_idx == '0) || w_tmo) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Frame assembly: collect words, register the padded frame on close.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy  <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= c_ones;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_buf  <= c_ones;
    end else begin
      r_rdy <= 1'b1;
      r_vld <= 1'b0;
      if (w_close) begin
        r_data <= w_frame;
        r_cnt  <= CNT_W'(r_idx) + CNT_W'(1);
        r_vld  <= 1'b1;
        r_buf  <= c_ones;
        r_idx  <= '0;
      end else if (w_beat) begin
        r_buf <= w_frame;
        r_idx <= r_idx + IDX_W'(1);
      end else if (w_tmo) begin
        // Unfilled slots of r_buf are still all-ones from the last reload.
        r_data <= r_buf;
        r_cnt  <= CNT_W'(r_idx);
        r_vld  <= 1'b1;
        r_buf  <= c_ones;
        r_idx  <= '0;
      end
    end
  end

  assign o_rdy  = r_rdy;
  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: doc/cm_sort_gather.md
# cm_sort_gather

Stream-to-frame collector placed directly upstream of `cm_sort`. It accepts one DWIDTH-bit word per handshake, packs DCNT consecutive words into a parallel frame and presents it with a single-cycle valid pulse, matching the sorter's `i_vld`/`i_data` input. Short frames, closed early by `i_last` or by an idle timeout, are padded with all-ones words. All-ones is the maximum value, so padding sorts to the top slots and the low `o_cnt` sorted outputs are the real data.

## Interface
- `DCNT`, 4, words per frame, ≥ 2
- `DWIDTH`, 16, bits per word, ≥ 1
- `TMO_CYC`, 16, idle cycles before a partial frame is flushed, ≥ 1; used only with `CM_SORT_GATHER_TMO_EN`
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_vld`  in  1  input word valid
- `o_rdy`  out  1  ready to accept a word
- `i_data`  in  DWIDTH  input word
- `i_last`  in  1  qualifies the accepted word as the last word of a frame
- `o_vld`  out  1  frame valid, one-cycle pulse, connects to sorter `i_vld`
- `o_data`  out  DCNT×DWIDTH  packed frame, slot 0 in the LSBs, connects to sorter `i_data`
- `o_cnt`  out  $clog2(DCNT+1)  number of real words in the frame, range 1..DCNT

## Operation
- Beat: `i_vld & o_rdy` at a rising edge.
- `o_rdy`:
  - 0 while in reset.
  - Registered; goes high on the first clock edge after `i_rst_n` deasserts.
  - Stays high afterwards. The sorter is fully pipelined, so the block never back-pressures.
- Internal state:
  - write index `idx`, range 0..DCNT-1
  - buffer of DCNT words, each initialised to all-ones
- States:
  - EMPTY when `idx` = 0.
  - FILL when `idx` > 0.
- On a beat, the word is written to slot `idx`.
- Close condition: a beat with `idx` = DCNT-1, or a beat with `i_last` = 1.
  - On close, the frame is registered into `o_data` as the buffer plus the incoming word, with unfilled slots all-ones.
  - `o_cnt` = `idx`+1.
  - `o_vld` = 1 on the next cycle.
  - The buffer is reloaded to all-ones and `idx` returns to 0 in the same edge.
- A beat without close increments `idx`. EMPTY moves to FILL.
- A new frame may begin on the cycle immediately after a close, so back-to-back frames need no bubble.
- `i_last` on the first word produces `o_cnt` = 1.
- `i_last` coinciding with `idx` = DCNT-1 produces one frame with `o_cnt` = DCNT, not an extra empty frame.
- `o_data` and `o_cnt` hold their values between pulses and change only on a close.
- Reset, including reset mid-frame:
  - `o_vld` = 0, `o_rdy` = 0, `o_data` = all-ones, `o_cnt` = 0, `idx` = 0.
  - A partial frame is discarded and never emitted.

## Timing
- Latency: 1 cycle from the closing beat edge to `o_vld` high.
- `o_vld` is high for exactly one cycle per frame.
- Throughput: one word per cycle sustained; a full frame can be emitted every DCNT cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `CM_SORT_GATHER_TMO_EN`.
- With the macro defined:
  - An idle counter runs in FILL and is cleared on every beat and in EMPTY.
  - When it reaches `TMO_CYC` with no beat, the partial frame closes: `o_vld` pulses on the next cycle with `o_cnt` = `idx`, unfilled slots all-ones, and the state returns to EMPTY.
  - A beat in the same cycle as the timeout threshold takes priority: the word is accepted and the counter clears.
- Without the macro: no counter is built, and a partial frame waits indefinitely for more words or `i_last`.

## Test plan
- Reset, then 4 beats 0x0005, 0x0003, 0x0009, 0x0001, `i_last` = 0 (DCNT = 4) -> one `o_vld` pulse 1 cycle after the 4th beat; `o_data` slots 0..3 = 5, 3, 9, 1; `o_cnt` = 4. Fed into `cm_sort`, the sorted output is 1, 3, 5, 9.
- 2 beats 0x0010, 0x0020 with `i_last` on the 2nd -> `o_cnt` = 2; slots 2 and 3 = 0xFFFF.
- 12 consecutive beats with `i_vld` held high -> 3 `o_vld` pulses spaced exactly 4 cycles apart; `o_rdy` never low.
- With `CM_SORT_GATHER_TMO_EN`, `TMO_CYC` = 16: 3 beats, then idle -> `o_vld` 17 cycles after the last beat, `o_cnt` = 3. Repeat with a 4th beat arriving exactly at the threshold cycle -> a full frame with `o_cnt` = 4 and no timeout frame.
- Assert `i_rst_n` low asynchronously mid-clock after 2 beats, release, then send 4 beats -> `o_vld` and `o_rdy` drop immediately; the only frame emitted is the post-reset frame, with `o_cnt` = 4.
